// File: rtl/dds_clock_gen.sv
// dds_clock_gen: multi-channel phase-accumulator clock generator.
// Each channel adds its active increment to an accumulator on every refclk
// edge. The wrap carry becomes a one-cycle clock enable, and the accumulator
// MSB becomes a ~50% square wave. Increments are double-buffered: a write
// lands in a shadow register and is promoted only on a wrap (or on cfg_sync),
// so a period is never shortened mid-flight.

module dds_clock_gen #(
  parameter int                   NUM_CHANNELS = 2,
  parameter int                   ACC_WIDTH    = 32,
  parameter int                   LOCK_CYCLES  = 1024,
  parameter logic [ACC_WIDTH-1:0] DEFAULT_INC  = ACC_WIDTH'(1081250501),
  parameter int                   AW           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    refclk,
  input  logic                    rst_n,
  input  logic                    cfg_write,
  input  logic                    cfg_read,
  input  logic [AW-1:0]           cfg_address,
  input  logic [ACC_WIDTH-1:0]    cfg_writedata,
  output logic [ACC_WIDTH-1:0]    cfg_readdata,
  input  logic                    cfg_sync,
  output logic [NUM_CHANNELS-1:0] clk_en,
  output logic [NUM_CHANNELS-1:0] outclk,
  output logic                    locked
);

  // Largest useful increment: one output toggle per refclk cycle.
  localparam logic [ACC_WIDTH-1:0] MAX_INC = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam int                   CW      = $clog2(LOCK_CYCLES + 1);
  localparam logic [CW-1:0]        LOCK_COUNT = CW'(LOCK_CYCLES);

  typedef enum logic {
    SETTLING,
    LOCKED
  } lock_state_t;

  logic [NUM_CHANNELS-1:0][ACC_WIDTH-1:0] acc;
  logic [NUM_CHANNELS-1:0][ACC_WIDTH-1:0] active_inc;
  logic [NUM_CHANNELS-1:0][ACC_WIDTH-1:0] shadow_inc;
  logic [NUM_CHANNELS-1:0][ACC_WIDTH:0]   sum;
  logic [NUM_CHANNELS-1:0]                pending;
  logic [NUM_CHANNELS-1:0]                write_hit;
  logic [NUM_CHANNELS-1:0]                apply_now;
  logic [ACC_WIDTH-1:0]                   wr_inc;
  logic [ACC_WIDTH-1:0]                   rd_inc;

  lock_state_t   lock_state;
  logic [CW-1:0] lock_count;

  // Per-channel next-sum, write decode, update-apply decision and read mux.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    wr_inc    = (cfg_writedata > MAX_INC) ? MAX_INC : cfg_writedata;
    rd_inc    = '0;
    write_hit = '0;
    apply_now = '0;
    sum       = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      sum[c]       = {1'b0, acc[c]} + {1'b0, active_inc[c]};
      // Addresses at or beyond NUM_CHANNELS match no channel, so they are
      // silently dropped for writes and read back as zero.
      write_hit[c] = cfg_write && (cfg_address == AW'(c));
      // A stopped channel never wraps, so it takes its update straight away.
      apply_now[c] = pending[c] && (sum[c][ACC_WIDTH] || (active_inc[c] == '0));
      if (cfg_address == AW'(c)) begin
        rd_inc = active_inc[c];
      end
    end
  end

  // Accumulators, increment double-buffers and registered clock outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: these per-channel arrays are plain flip-flops, not RAM, so giving
  // them an asynchronous reset is legal and keeps start-up deterministic.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        acc[c]        <= '0;
        active_inc[c] <= DEFAULT_INC;
        shadow_inc[c] <= DEFAULT_INC;
      end
      pending <= '0;
      clk_en  <= '0;
      outclk  <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (write_hit[c]) begin
          shadow_inc[c] <= wr_inc;
        end
        if (cfg_sync) begin
          // Realign: restart every phase at zero and promote whatever was
          // pending before this edge. A write on the same edge stays queued.
          acc[c]    <= '0;
          clk_en[c] <= 1'b0;
          outclk[c] <= 1'b0;
          if (pending[c]) begin
            active_inc[c] <= shadow_inc[c];
          end
          pending[c] <= write_hit[c];
        end else begin
          acc[c]    <= sum[c][ACC_WIDTH-1:0];
          clk_en[c] <= sum[c][ACC_WIDTH];
          outclk[c] <= sum[c][ACC_WIDTH-1];
          // The carry promotes the shadow as it stood before this edge, so a
          // colliding write is kept for the following wrap.
          if (apply_now[c]) begin
            active_inc[c] <= shadow_inc[c];
          end
          pending[c] <= write_hit[c] | (pending[c] & ~apply_now[c]);
        end
      end
    end
  end

  // Registered read port returning the active increment of the addressed channel.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_readdata <= '0;
    end else if (cfg_read) begin
      cfg_readdata <= rd_inc;
    end
  end

  // Lock FSM: count quiet cycles with nothing pending, drop on any reprogram.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_state <= SETTLING;
      lock_count <= '0;
      locked     <= 1'b0;
    end else begin
      case (lock_state)
        SETTLING: begin
          if ((|pending) || (|write_hit) || cfg_sync) begin
            lock_count <= '0;
          end else if (lock_count == LOCK_COUNT) begin
            lock_state <= LOCKED;
            locked     <= 1'b1;
          end else begin
            lock_count <= lock_count + 1'b1;
          end
        end
        LOCKED: begin
          if ((|write_hit) || cfg_sync) begin
            lock_state <= SETTLING;
            lock_count <= '0;
            locked     <= 1'b0;
          end
        end
        default: begin
          lock_state <= SETTLING;
          lock_count <= '0;
          locked     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_clock_gen.sv
// tb_dds_clock_gen: directed checks of dds_clock_gen with 2 channels,
// 8-bit accumulators, LOCK_CYCLES=16 and a reset increment of 64.

module tb_dds_clock_gen;

  logic       refclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       cfg_write = 1'b0;
  logic       cfg_read  = 1'b0;
  logic [0:0] cfg_address = '0;
  logic [7:0] cfg_writedata = '0;
  logic [7:0] cfg_readdata;
  logic       cfg_sync = 1'b0;
  logic [1:0] clk_en;
  logic [1:0] outclk;
  logic       locked;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_read;
    int         exp_first;   // cycles from sync to first pulse, 0 = none
  } vec_t;

  vec_t vecs[10];

  dds_clock_gen #(
    .NUM_CHANNELS(2),
    .ACC_WIDTH   (8),
    .LOCK_CYCLES (16),
    .DEFAULT_INC (8'd64)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .cfg_write    (cfg_write),
    .cfg_read     (cfg_read),
    .cfg_address  (cfg_address),
    .cfg_writedata(cfg_writedata),
    .cfg_readdata (cfg_readdata),
    .cfg_sync     (cfg_sync),
    .clk_en       (clk_en),
    .outclk       (outclk),
    .locked       (locked)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Advance one edge, then compare any read that was issued for that edge.
  task automatic tick();
    logic [7:0] exp;
    @(posedge refclk);
    #1;
    cyc++;
    cfg_write = 1'b0;
    cfg_sync  = 1'b0;
    if (cfg_read) begin
      cfg_read = 1'b0;
      if (exp_q.size() == 0) begin
        check("readdata_queue_empty", 32'd1, 32'd0);
      end else begin
        exp = exp_q.pop_front();
        check("readdata", 32'(cfg_readdata), 32'(exp));
      end
    end
  endtask

  task automatic write_cfg(input logic addr, input logic [7:0] data);
    cfg_write     = 1'b1;
    cfg_address   = addr;
    cfg_writedata = data;
  endtask

  task automatic read_req(input logic addr, input logic [7:0] exp);
    cfg_read    = 1'b1;
    cfg_address = addr;
    exp_q.push_back(exp);
  endtask

  task automatic do_reset();
    cfg_write = 1'b0;
    cfg_read  = 1'b0;
    cfg_sync  = 1'b0;
    exp_q.delete();
    rst_n = 1'b0;
    repeat (2) @(posedge refclk);
    @(negedge refclk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Free run from reset at increment 64: period 4, two high two low, lock at 17.
  task automatic run_free(input int n);
    logic [1:0] exp_ce, exp_oc;
    for (int k = 1; k <= n; k++) begin
      tick();
      exp_ce = (k % 4 == 0) ? 2'b11 : 2'b00;
      exp_oc = (k % 4 >= 2) ? 2'b11 : 2'b00;
      check("free_clk_en", 32'(clk_en), 32'(exp_ce));
      check("free_outclk", 32'(outclk), 32'(exp_oc));
      check("free_locked", 32'(locked), (k >= 17) ? 32'd1 : 32'd0);
      if (k == 9)  read_req(1'b0, 8'd64);
      if (k == 10) read_req(1'b1, 8'd64);
    end
  endtask

  initial begin
    logic [1:0] exp_ce, exp_oc;
    int j, first;

    vecs[0] = '{data: 8'd200, exp_read: 8'd128, exp_first: 2};
    vecs[1] = '{data: 8'd255, exp_read: 8'd128, exp_first: 2};
    vecs[2] = '{data: 8'd129, exp_read: 8'd128, exp_first: 2};
    vecs[3] = '{data: 8'd128, exp_read: 8'd128, exp_first: 2};
    vecs[4] = '{data: 8'd127, exp_read: 8'd127, exp_first: 3};
    vecs[5] = '{data: 8'd64,  exp_read: 8'd64,  exp_first: 4};
    vecs[6] = '{data: 8'd100, exp_read: 8'd100, exp_first: 3};
    vecs[7] = '{data: 8'd1,   exp_read: 8'd1,   exp_first: 256};
    vecs[8] = '{data: 8'd0,   exp_read: 8'd0,   exp_first: 0};
    vecs[9] = '{data: 8'd33,  exp_read: 8'd33,  exp_first: 8};

    // Reset release
    do_reset();
    check("rst_clk_en", 32'(clk_en), 32'd0);
    check("rst_outclk", 32'(outclk), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_readdata", 32'(cfg_readdata), 32'd0);
    run_free(21);

    // Write 128 to ch1 mid-period (acc=64): applies at the wrap on edge 24
    write_cfg(1'b1, 8'd128);
    for (int k = 22; k <= 42; k++) begin
      tick();
      exp_ce[0] = (k % 4 == 0);
      exp_oc[0] = (k % 4 >= 2);
      exp_ce[1] = (k <= 24) ? (k % 4 == 0) : (k % 2 == 0);
      exp_oc[1] = (k <= 24) ? (k % 4 >= 2) : (k % 2 == 1);
      check("wr_clk_en", 32'(clk_en), 32'(exp_ce));
      check("wr_outclk", 32'(outclk), 32'(exp_oc));
      check("wr_locked", 32'(locked), (k >= 41) ? 32'd1 : 32'd0);
      if (k == 22) read_req(1'b1, 8'd64);
      if (k == 29) read_req(1'b1, 8'd128);
    end

    // Clamp, stop, restart on ch0 (acc=128 now, ch1 runs at 128)
    write_cfg(1'b0, 8'd200);
    for (int k = 43; k <= 80; k++) begin
      tick();
      exp_ce[0] = (k == 44) || (k == 46) || (k == 48) || (k == 70) || (k == 78);
      exp_oc[0] = (k == 43) || (k == 45) || (k == 47) || ((k >= 62) && ((k - 62) % 8 >= 4));
      exp_ce[1] = (k % 2 == 0);
      exp_oc[1] = (k % 2 == 1);
      check("clamp_clk_en", 32'(clk_en), 32'(exp_ce));
      check("clamp_outclk", 32'(outclk), 32'(exp_oc));
      if (k == 44) read_req(1'b0, 8'd128);
      if (k == 46) write_cfg(1'b0, 8'd0);
      if (k == 60) write_cfg(1'b0, 8'd32);
      if (k == 63) read_req(1'b0, 8'd32);
    end

    // Write to ch0 landing exactly on its carry edge (edge 8)
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp_ce[0] = (k == 4) || (k == 8) || (k == 12) || (k == 20) || (k == 28);
      exp_oc[0] = (k <= 12) ? (k % 4 >= 2) : ((k - 12) % 8 >= 4);
      exp_ce[1] = (k % 4 == 0);
      exp_oc[1] = (k % 4 >= 2);
      check("coll_clk_en", 32'(clk_en), 32'(exp_ce));
      check("coll_outclk", 32'(outclk), 32'(exp_oc));
      if (k == 7) write_cfg(1'b0, 8'd32);
    end

    // cfg_sync with ch0 pending 32, plus a ch1 write on the sync edge
    do_reset();
    for (int k = 1; k <= 22; k++) begin
      tick();
      j = k - 6;
      if (k <= 5) begin
        exp_ce = (k % 4 == 0) ? 2'b11 : 2'b00;
        exp_oc = (k % 4 >= 2) ? 2'b11 : 2'b00;
      end else begin
        exp_ce[0] = (j > 0) && (j % 8 == 0);
        exp_oc[0] = (j % 8 >= 4);
        exp_ce[1] = (j >= 4) && (j % 2 == 0);
        exp_oc[1] = (j == 2) || (j == 3) || ((j >= 5) && (j % 2 == 1));
      end
      check("sync_clk_en", 32'(clk_en), 32'(exp_ce));
      check("sync_outclk", 32'(outclk), 32'(exp_oc));
      if (k == 4) write_cfg(1'b0, 8'd32);
      if (k == 5) begin
        cfg_sync = 1'b1;
        write_cfg(1'b1, 8'd128);
      end
      if (k == 6)  read_req(1'b0, 8'd32);
      if (k == 7)  read_req(1'b1, 8'd64);
      if (k == 11) read_req(1'b1, 8'd128);
    end

    // Asynchronous reset while ch1 has a pending update
    write_cfg(1'b1, 8'd32);
    tick();
    check("pre_rst_outclk1", 32'(outclk[1]), 32'd1);
    check("pre_rst_readdata", 32'(cfg_readdata), 32'd128);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_clk_en", 32'(clk_en), 32'd0);
    check("async_rst_outclk", 32'(outclk), 32'd0);
    check("async_rst_locked", 32'(locked), 32'd0);
    check("async_rst_readdata", 32'(cfg_readdata), 32'd0);
    do_reset();
    run_free(18);

    // Table: program ch1, sync, read back, time the first pulse
    for (int v = 0; v < 10; v++) begin
      write_cfg(1'b1, vecs[v].data);
      tick();
      cfg_sync = 1'b1;
      tick();
      read_req(1'b1, vecs[v].exp_read);
      first = 0;
      for (int n = 1; (n <= 300) && (first == 0); n++) begin
        tick();
        if (clk_en[1]) first = n;
      end
      check("table_first_pulse", 32'(first), 32'(vecs[v].exp_first));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog at cycle %0d: got timeout, expected completion", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
